// File: rtl/ucsbece154b_arb_pkg.sv
// Shared constants for the instruction/data memory arbiter:
// FSM state encodings, grant identifiers and timeout counter width.
package ucsbece154b_arb_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_IF_BUSY = 3'd1;
    localparam logic [2:0] ST_DM_BUSY = 3'd2;
    localparam logic [2:0] ST_IF_DROP = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        IF_BUSY = ST_IF_BUSY,
        DM_BUSY = ST_DM_BUSY,
        IF_DROP = ST_IF_DROP,
        RESP    = ST_RESP
    } arb_state_e;

    // Grant identifiers, also the encoding of the last_grant register.
    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_DM = 1'b1;

    // Wide enough for any TIMEOUT_CYCLES up to 65535.
    localparam int TMO_CNT_W = 16;

endpackage

// File: rtl/ucsbece154b_rr_pick.sv
// Two-way round-robin picker between fetch and data requests.
// grant_o/valid_o are combinational; last_grant advances only when the
// caller accepts the pick via update_i.
module ucsbece154b_rr_pick
    import ucsbece154b_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_if_i,
    input  logic req_dm_i,
    input  logic update_i,
    output logic valid_o,
    output logic grant_o
);

    logic last_q;

    // On a tie the requester that was not served last wins.
    always_comb begin
        valid_o = req_if_i | req_dm_i;
        grant_o = GRANT_IF;
        if (req_if_i && req_dm_i) grant_o = ~last_q;
        else if (req_dm_i)        grant_o = GRANT_DM;
    end

    // Remember the last accepted grant; reset to IF so DM wins the first tie.
    always_ff @(posedge clk) begin
        if (reset)         last_q <= GRANT_IF;
        else if (update_i) last_q <= grant_o;
    end

endmodule

// File: rtl/ucsbece154b_mem_arbiter.sv
// Shared memory port arbiter: fetch side vs data side, round-robin on ties,
// squashed-fetch drop, and access timeout with error pulse.
// Optional stall/conflict performance counters under MEMARB_PERF_EN.
module ucsbece154b_mem_arbiter
    import ucsbece154b_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_abort_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              stall_if_o,
    output logic              stall_dm_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              err_o
`ifdef MEMARB_PERF_EN
    ,
    output logic [31:0]       perf_if_stall_o,
    output logic [31:0]       perf_dm_stall_o,
    output logic [31:0]       perf_conflict_o
`endif
);

    arb_state_e           state_q, state_d;
    logic [TMO_CNT_W-1:0] cnt_q, cnt_d;
    logic                 gnt_q, gnt_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]    if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]    dm_rdata_q, dm_rdata_d;
    logic                 err_q, err_d;
    logic                 pick_vld, pick_gnt, pick_upd;
    logic                 tmo;

    ucsbece154b_rr_pick u_pick (
        .clk      (clk),
        .reset    (reset),
        .req_if_i (if_req_i),
        .req_dm_i (dm_req_i),
        .update_i (pick_upd),
        .valid_o  (pick_vld),
        .grant_o  (pick_gnt)
    );

    // >= rather than == so an abort landing on the last allowed cycle still
    // times out one cycle later in IF_DROP.
    assign tmo = (cnt_q >= TMO_CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state and datapath capture for the arbitration FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        err_d       = 1'b0;
        pick_upd    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    pick_upd  = 1'b1;
                    gnt_d     = pick_gnt;
                    cnt_d     = '0;
                    mem_req_d = 1'b1;
                    if (pick_gnt == GRANT_DM) begin
                        mem_we_d    = dm_we_i;
                        mem_addr_d  = dm_addr_i;
                        mem_wdata_d = dm_wdata_i;
                        state_d     = DM_BUSY;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                        state_d     = IF_BUSY;
                    end
                end
            end
            IF_BUSY: begin
                cnt_d = cnt_q + TMO_CNT_W'(1);
                if (if_abort_i) begin
                    // An ack in the same cycle is consumed here: mem_req drops
                    // and IF_DROP sees mem_req low and drains straight to IDLE.
                    if (mem_ack_i) mem_req_d = 1'b0;
                    state_d = IF_DROP;
                end else if (mem_ack_i) begin
                    if_rdata_d = mem_rdata_i;
                    mem_req_d  = 1'b0;
                    state_d    = RESP;
                end else if (tmo) begin
                    if_rdata_d = '0;
                    mem_req_d  = 1'b0;
                    err_d      = 1'b1;
                    state_d    = RESP;
                end
            end
            DM_BUSY: begin
                cnt_d = cnt_q + TMO_CNT_W'(1);
                if (mem_ack_i) begin
                    if (!mem_we_q) dm_rdata_d = mem_rdata_i;
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end else if (tmo) begin
                    dm_rdata_d = '0;
                    mem_req_d  = 1'b0;
                    err_d      = 1'b1;
                    state_d    = RESP;
                end
            end
            IF_DROP: begin
                cnt_d = cnt_q + TMO_CNT_W'(1);
                if (!mem_req_q || mem_ack_i) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (tmo) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gnt_q       <= GRANT_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            err_q       <= err_d;
        end
    end

    assign if_ready_o  = (state_q == RESP) && (gnt_q == GRANT_IF);
    assign dm_ready_o  = (state_q == RESP) && (gnt_q == GRANT_DM);
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign err_o       = err_q;
    assign stall_if_o  = if_req_i & ~if_ready_o;
    assign stall_dm_o  = dm_req_i & ~dm_ready_o;

`ifdef MEMARB_PERF_EN
    logic [31:0] perf_if_q, perf_dm_q, perf_cf_q;

    // Saturating stall and IDLE-conflict counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_if_q <= '0;
            perf_dm_q <= '0;
            perf_cf_q <= '0;
        end else begin
            if (stall_if_o && perf_if_q != '1) perf_if_q <= perf_if_q + 32'd1;
            if (stall_dm_o && perf_dm_q != '1) perf_dm_q <= perf_dm_q + 32'd1;
            if (state_q == IDLE && if_req_i && dm_req_i && perf_cf_q != '1)
                perf_cf_q <= perf_cf_q + 32'd1;
        end
    end

    assign perf_if_stall_o = perf_if_q;
    assign perf_dm_stall_o = perf_dm_q;
    assign perf_conflict_o = perf_cf_q;
`endif

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Scoreboard bench for the memory arbiter: drivers push expected read data
// into per-requester queues, a negedge monitor pops on each ready pulse.
module tb_ucsbece154b_mem_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_i, if_abort_i, dm_req_i, dm_we_i, mem_ack_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
    logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
    logic        if_ready_o, dm_ready_o, stall_if_o, stall_dm_o;
    logic        mem_req_o, mem_we_o, err_o;
`ifdef MEMARB_PERF_EN
    logic [31:0] perf_if_stall_o, perf_dm_stall_o, perf_conflict_o;
`endif

    ucsbece154b_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_abort_i  (if_abort_i),
        .if_rdata_o  (if_rdata_o),
        .if_ready_o  (if_ready_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_ready_o  (dm_ready_o),
        .stall_if_o  (stall_if_o),
        .stall_dm_o  (stall_dm_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .err_o       (err_o)
`ifdef MEMARB_PERF_EN
        ,
        .perf_if_stall_o (perf_if_stall_o),
        .perf_dm_stall_o (perf_dm_stall_o),
        .perf_conflict_o (perf_conflict_o)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] if_q[$];
    logic [31:0] dm_q[$];
    logic [31:0] glog[$];
    logic [31:0] mem[logic [31:0]];
    int          lat = 1;
    int          mcnt = 0;
    int          err_seen = 0;
    logic        stray_ack = 1'b0;
    logic        req_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        if (a == 32'h100)  return 32'hDEADBEEF;
        return a ^ 32'hA5A5A5A5;
    endfunction

    // Memory: acks once mem_req_o has been high for lat+1 negedges.
    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (reset || !mem_req_o) mcnt = 0;
            else                     mcnt = mcnt + 1;
            mem_ack_i = stray_ack || (mem_req_o && !reset && mcnt == lat + 1);
            if (stray_ack)                  mem_rdata_i = 32'h12345678;
            else if (mem_ack_i && !mem_we_o) mem_rdata_i = rd_model(mem_addr_o);
            else                            mem_rdata_i = '0;
            if (mem_ack_i && mem_req_o && mem_we_o) mem[mem_addr_o] = mem_wdata_o;
        end
    end

    // Monitor: scoreboard pops on ready pulses, logs grants and err pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (if_ready_o) begin
                if (if_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL if_unexpected_ready: got rdata %h expected no pulse", if_rdata_o);
                end else chk("if_rdata", if_rdata_o, if_q.pop_front());
            end
            if (dm_ready_o) begin
                if (dm_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dm_unexpected_ready: got rdata %h expected no pulse", dm_rdata_o);
                end else chk("dm_rdata", dm_rdata_o, dm_q.pop_front());
            end
            if (err_o) err_seen++;
            if (mem_req_o && !req_prev) glog.push_back(mem_addr_o);
            req_prev = mem_req_o;
        end
    end

    task automatic if_access(input logic [31:0] a, input logic [31:0] exp);
        int n;
        if_addr_i = a; if_req_i = 1'b1; if_q.push_back(exp); n = 0;
        do begin @(negedge clk); n++; end while (!if_ready_o && n < 100);
        if (!if_ready_o) begin
            checks++; errors++;
            $display("FAIL if_wait addr %h: got no ready in %0d cycles expected ready", a, n);
        end
        if_req_i = 1'b0;
    endtask

    task automatic dm_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] exp);
        int n;
        dm_we_i = we; dm_addr_i = a; dm_wdata_i = wd; dm_req_i = 1'b1;
        dm_q.push_back(exp); n = 0;
        do begin @(negedge clk); n++; end while (!dm_ready_o && n < 100);
        if (!dm_ready_o) begin
            checks++; errors++;
            $display("FAIL dm_wait addr %h: got no ready in %0d cycles expected ready", a, n);
        end
        dm_req_i = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Timed DM load: returns cycles to ready and err_o/mem_req_o seen there.
    task automatic dm_timed(input logic [31:0] a, input logic [31:0] exp,
                            output int n, output logic e, output logic r);
        dm_we_i = 1'b0; dm_addr_i = a; dm_req_i = 1'b1; dm_q.push_back(exp); n = 0;
        do begin @(negedge clk); n++; end while (!dm_ready_o && n < 40);
        e = err_o; r = mem_req_o;
        dm_req_i = 1'b0;
    endtask

    initial begin
        int          n;
        int          e0;
        logic        e, r;
        logic [31:0] exp_order[6];
        reset = 1'b1;
        if_req_i = 0; if_abort_i = 0; if_addr_i = 0;
        dm_req_i = 0; dm_we_i = 0; dm_addr_i = 0; dm_wdata_i = 0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_ready", {if_ready_o, dm_ready_o, err_o}, 0);
        chk("rst_if_rdata", if_rdata_o, 0);
        chk("rst_dm_rdata", dm_rdata_o, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single load, 1-cycle memory: ready on the third cycle after req.
        lat = 1;
        dm_we_i = 0; dm_addr_i = 32'h100; dm_req_i = 1; dm_q.push_back(32'hDEADBEEF);
        #1 chk("t1_stall_c0", stall_dm_o, 1);
        @(negedge clk);
        chk("t1_mem_req", mem_req_o, 1);
        chk("t1_mem_addr", mem_addr_o, 32'h100);
        chk("t1_stall_c1", {stall_dm_o, dm_ready_o}, 2'b10);
        @(negedge clk);
        chk("t1_stall_c2", {stall_dm_o, dm_ready_o}, 2'b10);
        @(negedge clk);
        chk("t1_ready_c3", {stall_dm_o, dm_ready_o}, 2'b01);
        dm_req_i = 0;
        @(negedge clk);

        // Contention from reset: DM first, then alternating.
        do_reset();
        glog.delete();
        fork
            begin
                dm_access(1'b1, 32'h200, 32'h55, 32'h0);
                dm_access(1'b0, 32'h200, 32'h0, 32'h55);
                dm_access(1'b0, 32'h100, 32'h0, 32'hDEADBEEF);
            end
            begin
                if_access(32'h0, 32'hA5A5A5A5);
                if_access(32'h4, 32'hA5A5A5A1);
                if_access(32'h8, 32'hA5A5A5AD);
            end
            begin
                @(negedge clk);
                chk("t2_first_we", mem_we_o, 1);
                chk("t2_first_addr", mem_addr_o, 32'h200);
                chk("t2_first_wdata", mem_wdata_o, 32'h55);
            end
        join
        exp_order = '{32'h200, 32'h0, 32'h200, 32'h4, 32'h100, 32'h8};
        chk("t2_grant_count", glog.size(), 6);
        for (int i = 0; i < 6 && i < glog.size(); i++) chk($sformatf("t2_grant%0d", i), glog[i], exp_order[i]);
        @(negedge clk);

        // Squash: fetch 0x40 latency 5, abort in cycle 2, redirect to 0x80.
        lat = 5;
        e0 = err_seen;
        if_addr_i = 32'h40; if_req_i = 1;
        @(negedge clk);
        chk("t3_req_c1", mem_req_o, 1);
        @(negedge clk);
        if_abort_i = 1; if_addr_i = 32'h80;
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            if_abort_i = 0;
            chk($sformatf("t3_hold_c%0d", c), {mem_req_o, if_ready_o}, 2'b10);
            chk($sformatf("t3_addr_c%0d", c), mem_addr_o, 32'h40);
        end
        @(negedge clk);
        chk("t3_req_c7", {mem_req_o, if_ready_o}, 2'b00);
        chk("t3_rdata_kept", if_rdata_o, 32'hA5A5A5AD);
        lat = 1;
        if_q.push_back(32'hA5A5A525);
        @(negedge clk);
        chk("t3_regrant", {mem_req_o, mem_addr_o}, {1'b1, 32'h80});
        n = 0;
        do begin @(negedge clk); n++; end while (!if_ready_o && n < 20);
        chk("t3_ready_lat", n, 2);
        if_req_i = 0;
        chk("t3_no_err", err_seen - e0, 0);
        @(negedge clk);

        // Ack in the last allowed cycle completes without error.
        lat = TMO - 1;
        e0 = err_seen;
        dm_timed(32'h300, 32'hA5A5A6A5, n, e, r);
        chk("t4_cycles", n, 9);
        chk("t4_err", {e, r}, 2'b00);
        @(negedge clk);
        chk("t4_err_total", err_seen - e0, 0);

        // Timeout: memory never acks a load.
        lat = 1000;
        dm_timed(32'h304, 32'h0, n, e, r);
        chk("t5_cycles", n, 9);
        chk("t5_err_req", {e, r}, 2'b10);
        @(negedge clk);
        chk("t5_err_cleared", err_o, 0);

        // Reset mid-access, then a stray ack in IDLE.
        lat = 3;
        dm_we_i = 0; dm_addr_i = 32'h100; dm_req_i = 1;
        repeat (2) @(negedge clk);
        reset = 1; dm_req_i = 0;
        @(negedge clk);
        chk("t6_mem_req", mem_req_o, 0);
        chk("t6_mem_addr", mem_addr_o, 0);
        chk("t6_flags", {dm_ready_o, err_o, mem_we_o}, 0);
        reset = 0;
        stray_ack = 1;
        repeat (2) @(negedge clk);
        stray_ack = 0;
        repeat (2) @(negedge clk);
        chk("t6_stray_rdata", dm_rdata_o, 0);
        chk("t6_stray_req", mem_req_o, 0);

`ifdef MEMARB_PERF_EN
        do_reset();
        lat = 1;
        if_access(32'h10, 32'hA5A5A5B5);
        if_access(32'h14, 32'hA5A5A5B1);
        @(negedge clk);
        chk("perf_if_stall", perf_if_stall_o, 6);
        chk("perf_dm_stall", perf_dm_stall_o, 0);
        chk("perf_conflict", perf_conflict_o, 0);
`endif

        repeat (2) @(negedge clk);
        chk("if_sb_empty", if_q.size(), 0);
        chk("dm_sb_empty", dm_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
